// File: rtl/lane_rr_arbiter.sv
// rtl/lane_rr_arbiter.sv - round-robin arbiter sharing one lane between NUM_REQ requesters
module lane_rr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 1,
    parameter int MAX_BURST  = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ-1:0]              req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]              gnt,
    output logic                            out_valid,
    output logic [DATA_WIDTH-1:0]           out_data,
    input  logic                            out_ready,
    output logic [$clog2(NUM_REQ)-1:0]      out_idx,
    output logic                            busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   r_ptr;
    logic [CNT_W-1:0]   r_beat_cnt;
    logic [NUM_REQ-1:0] r_gnt;

    logic [IDX_W-1:0]   w_sel_idx;
    logic [NUM_REQ-1:0] w_sel_onehot;
    logic               w_any;
    logic               w_cur_req;
    logic               w_cur_last;
    logic               w_xfer;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_done;

    // Wrap-around search from ptr+1; iterating downward lets the nearest hit win.
    always_comb begin
        w_sel_idx = '0;
        w_any     = |req;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req[(int'(r_ptr) + k) % NUM_REQ]) begin
                w_sel_idx = IDX_W'((int'(r_ptr) + k) % NUM_REQ);
            end
        end
        w_sel_onehot = '0;
        w_sel_onehot[w_sel_idx] = 1'b1;
    end

    always_comb begin
        w_cur_req  = req[r_idx];
        w_cur_last = req_last[r_idx];
        w_xfer     = (r_state == S_GRANT) && w_cur_req && out_ready;
        w_cnt_next = r_beat_cnt + CNT_W'(1);
        w_done     = w_xfer && (w_cur_last || (w_cnt_next == CNT_W'(MAX_BURST)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Withdrawal ends the grant in the same cycle it is seen; no beat happens then.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_next = S_GRANT;
                end
            end
            S_GRANT: begin
                if (!w_cur_req || w_done) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_ptr      <= IDX_W'(NUM_REQ - 1);
            r_beat_cnt <= '0;
            r_gnt      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_idx      <= w_sel_idx;
                        r_ptr      <= w_sel_idx;
                        r_beat_cnt <= '0;
                        r_gnt      <= w_sel_onehot;
                    end
                end
                S_GRANT: begin
                    if (w_xfer) begin
                        r_beat_cnt <= w_cnt_next;
                    end
                    if (w_state_next == S_IDLE) begin
                        r_gnt <= '0;
                    end
                end
                default: r_gnt <= '0;
            endcase
        end
    end

    always_comb begin
        busy      = (r_state == S_GRANT);
        gnt       = r_gnt;
        out_valid = busy && w_cur_req;
        out_data  = busy ? req_data[int'(r_idx)*DATA_WIDTH +: DATA_WIDTH] : '0;
        out_idx   = busy ? r_idx : '0;
    end

endmodule

// File: doc/lane_rr_arbiter.md
# lane_rr_arbiter

Round-robin arbiter that shares one datapath lane of the replicated `child` array between `NUM_REQ` requesters. Grants are registered and one-hot, and each grant holds for a bounded burst. The granted requester's data is muxed onto a single valid/ready output that feeds the lane's `a` input. The block sits in the parent wrapper, one instance per shared lane.

## Interface
- `NUM_REQ`, 4, number of requesters (≥2)
- `DATA_WIDTH`, 1, width of one beat
- `MAX_BURST`, 4, maximum beats per grant (≥1)
- `clk` input 1: sole clock, rising edge
- `rst_n` input 1: reset, asynchronous, active-low
- `req` input NUM_REQ: per-requester request, level
- `req_last` input NUM_REQ: per-requester last-beat flag, sampled only on a transferred beat
- `req_data` input NUM_REQ×DATA_WIDTH: per-requester beat data
- `gnt` output NUM_REQ: registered one-hot grant
- `out_valid` output 1: beat valid toward lane
- `out_data` output DATA_WIDTH: beat data toward lane
- `out_ready` input 1: lane accepts beat
- `out_idx` output clog2(NUM_REQ): index of current grantee; 0 when idle
- `busy` output 1: grant active

## Operation
- Two-state FSM:
  - IDLE: `gnt`=0.
  - GRANT: exactly one `gnt` bit set.
- Beat transfer: cycle with `out_valid && out_ready`.
- Combinational outputs in GRANT:
  - `out_valid` = `req[idx]`.
  - `out_data` = `req_data[idx]`.
  - In IDLE: `out_valid`=0, `out_data`=0.
- IDLE→GRANT, when any `req` bit is set:
  - Select the first set bit searching upward from `ptr+1` and wrapping modulo `NUM_REQ`.
  - Register `idx`.
  - Set `ptr`=`idx`.
  - Clear `beat_cnt`.
- GRANT→IDLE, on the first of:
  - a transferred beat with `req_last[idx]`=1;
  - a transferred beat that makes `beat_cnt`=`MAX_BURST`;
  - `req[idx]`=0, i.e. the requester withdrew. No beat occurs in this cycle.
- `beat_cnt` is clog2(MAX_BURST+1) bits. It increments on each transferred beat, never exceeds `MAX_BURST`, and clears on entry to GRANT.
- Non-granted requesters see no effect from their `req_last`/`req_data`.
- `ptr` updates only at grant. Withdrawal still advances priority past the withdrawn requester.
- Reset values: state IDLE, `gnt`=0, `busy`=0, `out_valid`=0, `out_data`=0, `out_idx`=0, `beat_cnt`=0, `ptr`=NUM_REQ-1 (requester 0 wins first).
- Reset asserted mid-burst: all state returns to reset values immediately, with no further beats. After release, arbitration restarts from requester 0.

## Timing
- Request-to-grant latency is 1 cycle: `req` sampled in IDLE at edge N gives `gnt`/`busy` high after edge N.
- The first beat may transfer in the first GRANT cycle.
- End of burst:
  - The terminating beat or withdrawal at cycle k sets `gnt`=0 at k+1 (IDLE).
  - The next grant is visible at k+2.
  - There is exactly one dead cycle between consecutive grants.
- `out_ready` low stalls the burst indefinitely. The grant is held, `beat_cnt` is unchanged, and `out_data` tracks `req_data[idx]` combinationally.
- `req_last` and `beat_cnt`=`MAX_BURST` on the same beat give a single termination with no double count.
- Simultaneous requests in IDLE resolve by wrap-around priority only; there is no fixed priority apart from the reset state of `ptr`.

## Test plan
- **Reset default.** Hold `rst_n`=0, then release with `req`=4'b1111 → `gnt`=4'b0001 one cycle after release, `out_idx`=0.
- **Rotation.**
  - Inputs: `req`=4'b1111 constant, `out_ready`=1, `req_last`=1 always.
  - Expected: grants 0,1,2,3,0 on cycles 1,3,5,7,9.
  - Expected: `gnt`=0 on the even cycles between them.
- **Burst cap.**
  - Inputs: `MAX_BURST`=4, single `req`=4'b0100, `req_last`=0, `out_ready`=1.
  - Expected: exactly 4 beats with `out_idx`=2, then 1 idle cycle, then re-grant to 2.
- **Stall.**
  - Inputs: grant to requester 1, `out_ready`=0 for 5 cycles, then 1 with `req_last`=1.
  - Expected: `gnt`=4'b0010 held 6 cycles, 1 beat, then IDLE.
- **Withdrawal.**
  - Inputs: grant to requester 3, which drops `req` after 1 beat while `req`[0] is set.
  - Expected: IDLE next cycle, then grant to 0 (wrap past 3).
- **Reset mid-burst.**
  - Inputs: assert `rst_n`=0 during the 2nd beat of a requester-2 burst.
  - Expected: `gnt`=0 and `out_valid`=0 asynchronously. After release with `req`=4'b0110, grant goes to 1.
